// File: rtl/filter_sequencer.sv
// filter_sequencer
//   Sample scheduler and coefficient manager for a single-section IIR filter.
//   Incoming samples queue in a small FIFO. One sample is issued per sample
//   period (DIV clocks). The filter state-register enable is pulsed for the
//   issue cycle only. The filter result is captured behind a valid/ready
//   handshake. Coefficient updates are staged in shadow registers and copied
//   to the active set only while idle.
//
// Parameters
//   W     : sample / coefficient width
//   DIV   : sample period in clk cycles (>= 3)
//   DEPTH : input FIFO entries (power of 2)
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready   : sample input stream
//   cfg_wr/cfg_addr/cfg_data    : shadow coefficient write (0=a1, 1=b0, 2=b1)
//   cfg_commit                  : request shadow -> active copy
//   filt_x, filt_en             : filter input sample and state enable
//   filt_a1, filt_b0, filt_b1   : active coefficients
//   filt_y                      : combinational filter output
//   out_data/out_valid/out_ready: captured result stream
//   busy                        : not idle, or samples queued
//   miss_cnt                    : saturating missed-tick count
//
// Build option
//   FILTSEQ_MISS_CNT_EN : when defined, miss_cnt counts missed ticks
//                         (saturating at 255); otherwise miss_cnt is 0.
module filter_sequencer #(
  parameter int W     = 32,
  parameter int DIV   = 50,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cfg_wr,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         cfg_commit,
  output logic [W-1:0] filt_x,
  output logic         filt_en,
  output logic [W-1:0] filt_a1,
  output logic [W-1:0] filt_b0,
  output logic [W-1:0] filt_b1,
  input  logic [W-1:0] filt_y,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [7:0]   miss_cnt
);

  localparam int CW = $clog2(DIV);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, empty;
  logic [W-1:0]  x_q;
  logic [W-1:0]  sh_a1, sh_b0, sh_b1;
  logic          pending, load;

  // Sample-period tick counter
  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  // Input FIFO; in_ready comes from registered occupancy only
  assign empty    = (count == '0);
  assign in_ready = (count != (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    filt_en = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:    if (tick && !empty) begin
                 pop     = 1'b1;
                 state_d = ISSUE;
               end
      ISSUE:   begin
                 filt_en = 1'b1;
                 state_d = OUT;
               end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) || !empty;

  // Issued sample register and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      x_q <= '0;
    else if (pop) x_q <= mem[rd_ptr];
  end

  assign filt_x = x_q;

  // The result is captured at the same edge the filter state advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (state_q == ISSUE) begin
      out_data  <= filt_y;
      out_valid <= 1'b1;
    end else if ((state_q == OUT) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Coefficients: shadow writes are immediate, active copy only while idle.
  // A commit arriving on the copy edge re-arms pending so it is not lost.
  assign load = (state_q == IDLE) && pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a1   <= '0;
      sh_b0   <= '0;
      sh_b1   <= '0;
      filt_a1 <= '0;
      filt_b0 <= '0;
      filt_b1 <= '0;
      pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        case (cfg_addr)
          2'd0:    sh_a1 <= cfg_data;
          2'd1:    sh_b0 <= cfg_data;
          2'd2:    sh_b1 <= cfg_data;
          default: ;
        endcase
      end
      if (load) begin
        filt_a1 <= sh_a1;
        filt_b0 <= sh_b0;
        filt_b1 <= sh_b1;
      end
      pending <= cfg_commit | (pending & ~load);
    end
  end

  // Missed ticks: every tick that does not pop a sample
`ifdef FILTSEQ_MISS_CNT_EN
  logic       miss;
  logic [7:0] miss_q;

  assign miss = tick & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         miss_q <= '0;
    else if (miss && miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
  end

  assign miss_cnt = miss_q;
`else
  assign miss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_filter_sequencer.sv
// Testbench for filter_sequencer (W=32, DIV=4, DEPTH=4).
// A simple behavioural IIR section supplies filt_y. A transaction-level
// reference model (sample queue, phase, coefficient sets, miss count) is
// advanced on every clock and used for expectations.
module tb_filter_sequencer;
  localparam int W     = 32;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         cfg_wr = 1'b0;
  logic [1:0]   cfg_addr = 2'd0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_commit = 1'b0;
  logic [W-1:0] filt_x, filt_a1, filt_b0, filt_b1, filt_y, out_data;
  logic         filt_en, out_valid, busy;
  logic         out_ready = 1'b1;
  logic [7:0]   miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_sequencer #(.W(W), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .filt_x(filt_x), .filt_en(filt_en),
    .filt_a1(filt_a1), .filt_b0(filt_b0), .filt_b1(filt_b1), .filt_y(filt_y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .miss_cnt(miss_cnt)
  );

  // Filter section driven by the DUT: y = b0*x + b1*x[n-1] + a1*y[n-1]
  logic [W-1:0] ex_p, ey_p;
  assign filt_y = filt_b0 * filt_x + filt_b1 * ex_p + filt_a1 * ey_p;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_p <= '0;
      ey_p <= '0;
    end else if (filt_en) begin
      ex_p <= filt_x;
      ey_p <= filt_y;
    end
  end

  // Reference model
  logic [W-1:0] mq[$];
  int           mph;      // 0 waiting for tick, 1 issuing, 2 holding result
  int           mcnt;
  int           mmiss;
  logic [W-1:0] mx, modata, rxp, ryp;
  logic [W-1:0] ma[3];    // active a1, b0, b1
  logic [W-1:0] ms[3];    // shadow a1, b0, b1
  bit           movalid, mpend;

  always @(posedge clk or posedge rst) begin : model
    bit tk, pushok;
    logic [W-1:0] y;
    if (rst) begin
      mq.delete();
      mph = 0; mcnt = 0; mmiss = 0;
      mx = '0; modata = '0; rxp = '0; ryp = '0;
      movalid = 0; mpend = 0;
      for (int i = 0; i < 3; i++) begin ma[i] = '0; ms[i] = '0; end
    end else begin
      tk     = (mcnt == DIV - 1);
      pushok = in_valid && (mq.size() < DEPTH);
      y      = ma[1] * mx + ma[2] * rxp + ma[0] * ryp;
      if (tk && !(mph == 0 && mq.size() > 0)) begin
`ifdef FILTSEQ_MISS_CNT_EN
        if (mmiss < 255) mmiss++;
`endif
      end
      if (mph == 0 && mpend) begin
        for (int i = 0; i < 3; i++) ma[i] = ms[i];
        mpend = 0;
      end
      if (cfg_commit) mpend = 1;
      if (cfg_wr && cfg_addr != 2'd3) ms[cfg_addr] = cfg_data;
      case (mph)
        0: if (tk && mq.size() > 0) begin mx = mq.pop_front(); mph = 1; end
        1: begin modata = y; movalid = 1; rxp = mx; ryp = y; mph = 2; end
        default: if (out_ready) begin movalid = 0; mph = 0; end
      endcase
      if (pushok) mq.push_back(in_data);
      mcnt = (mcnt + 1) % DIV;
    end
  end

  logic [W-1:0] coef_x;   // sample issued in test_coef_commit

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, filt_en, in_ready, busy} !== 4'b0010) begin
      errors++; $display("FAIL reset_flags got %b want 0010", {out_valid, filt_en, in_ready, busy});
    end
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== '0) begin
      errors++; $display("FAIL reset_coef got %h %h %h want 0", filt_a1, filt_b0, filt_b1);
    end
    checks++;
    if (out_data !== '0 || filt_x !== '0 || miss_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_data got out=%h x=%h miss=%0d want 0", out_data, filt_x, miss_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_empty_ticks();
    logic [7:0] exp_miss;
`ifdef FILTSEQ_MISS_CNT_EN
    exp_miss = 8'd3;
`else
    exp_miss = 8'd0;
`endif
    repeat (3 * DIV) begin
      @(negedge clk);
      checks++;
      if (filt_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL empty_idle got en=%b busy=%b want 0 0", filt_en, busy);
      end
    end
    checks++;
    if (miss_cnt !== exp_miss) begin
      errors++; $display("FAIL empty_miss got %0d want %0d", miss_cnt, exp_miss);
    end
  endtask

  task automatic test_coef_commit();
    bit ok;
    @(negedge clk); cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_data = 32'h11;
    @(negedge clk); cfg_addr = 2'd1; cfg_data = 32'h22;
    @(negedge clk); cfg_addr = 2'd2; cfg_data = 32'h33;
    @(negedge clk); cfg_wr = 1'b0;
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== '0) begin
      errors++; $display("FAIL coef_nocommit got %h %h %h want 0", filt_a1, filt_b0, filt_b1);
    end
    coef_x    = $urandom;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = coef_x;
    @(negedge clk); in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 3 * DIV && !ok; i++) begin @(negedge clk); ok = out_valid; end
    checks++;
    if (!ok) begin errors++; $display("FAIL coef_wait_out got 0 want 1"); end
    cfg_commit = 1'b1;
    @(negedge clk); cfg_commit = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({filt_a1, filt_b0, filt_b1} !== '0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL coef_during_out got %h %h %h v=%b want 0 0 0 v=1",
                           filt_a1, filt_b0, filt_b1, out_valid);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL coef_first_idle got %h %h %h v=%b want 0 0 0 v=0",
                         filt_a1, filt_b0, filt_b1, out_valid);
    end
    @(negedge clk);
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== {32'h11, 32'h22, 32'h33}) begin
      errors++; $display("FAIL coef_applied got %h %h %h want 11 22 33", filt_a1, filt_b0, filt_b1);
    end
  endtask

  task automatic test_basic_issue();
    int pulses, seen;
    logic [W-1:0] expy;
    expy   = 32'h22 * 32'h10 + 32'h33 * coef_x;   // previous y was 0 (zero coefficients)
    pulses = 0;
    seen   = -10;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 32'h10;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      if (filt_en) begin
        pulses++;
        seen = i;
        checks++;
        if (filt_x !== 32'h10) begin errors++; $display("FAIL basic_x got %h want 10", filt_x); end
        checks++;
        if (mcnt !== 0) begin errors++; $display("FAIL basic_tick_align got cnt %0d want 0", mcnt); end
      end
      if (i == seen + 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== expy) begin
          errors++; $display("FAIL basic_out got v=%b %h want v=1 %h", out_valid, out_data, expy);
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int ticks, got_b;
    logic [W-1:0] a, b, hold;
    logic [7:0] m0, exp_delta;
    a = $urandom; b = $urandom;
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = a;
    @(negedge clk); in_data = b;
    @(negedge clk); in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 3 * DIV && !ok; i++) begin @(negedge clk); ok = out_valid; end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_wait_out got 0 want 1"); end
    hold  = out_data;
    m0    = miss_cnt;
    ticks = (mcnt == DIV - 1) ? 1 : 0;
    checks++;
    if (hold !== modata) begin errors++; $display("FAIL bp_result got %h want %h", hold, modata); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mcnt == DIV - 1) ticks++;
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold || filt_en !== 1'b0) begin
        errors++; $display("FAIL bp_hold got v=%b %h en=%b want v=1 %h en=0", out_valid, out_data, filt_en, hold);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
`ifdef FILTSEQ_MISS_CNT_EN
    exp_delta = 8'(ticks);
`else
    exp_delta = 8'd0;
`endif
    checks++;
    if (8'(miss_cnt - m0) !== exp_delta) begin
      errors++; $display("FAIL bp_miss got %0d want %0d", 8'(miss_cnt - m0), exp_delta);
    end
    got_b = 0;
    for (int i = 0; i < 3 * DIV && got_b == 0; i++) begin
      @(negedge clk);
      if (filt_en) begin
        got_b = 1;
        checks++;
        if (filt_x !== b) begin errors++; $display("FAIL bp_second got %h want %h", filt_x, b); end
      end
    end
    checks++;
    if (got_b == 0) begin errors++; $display("FAIL bp_second_issue got none want one"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fifo_full();
    logic [W-1:0] s[6];
    logic [W-1:0] got[$];
    bit ok, go;
    for (int i = 0; i < 6; i++) s[i] = $urandom;
    ok = 0;
    for (int i = 0; i < 8 * DIV && !ok; i++) begin @(negedge clk); ok = !busy; end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = s[0];
    @(negedge clk); in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 3 * DIV && !ok; i++) begin @(negedge clk); ok = out_valid; end
    checks++;
    if (!ok) begin errors++; $display("FAIL full_wait_out got 0 want 1"); end
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = s[k];
      @(negedge clk);
    end
    repeat (3) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    go = 0;
    for (int i = 0; i < 12 * DIV && got.size() < 5; i++) begin
      @(negedge clk);
      if (go) in_valid = 1'b0;
      if (in_valid && in_ready) go = 1;
      if (filt_en) got.push_back(filt_x);
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL full_count got %0d want 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== s[i + 1]) begin
        errors++; $display("FAIL full_order[%0d] got %h want %h", i, got[i], s[i + 1]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, filt_en, in_ready, busy} !==
          {movalid, mph == 1, mq.size() < DEPTH, (mph != 0) || (mq.size() > 0)}) begin
        errors++; $display("FAIL rnd_flags cyc %0d got %b want %b", i, {out_valid, filt_en, in_ready, busy},
                           {movalid, mph == 1, mq.size() < DEPTH, (mph != 0) || (mq.size() > 0)});
      end
      checks++;
      if (out_data !== modata || filt_x !== mx) begin
        errors++; $display("FAIL rnd_data cyc %0d got %h %h want %h %h", i, out_data, filt_x, modata, mx);
      end
      checks++;
      if ({filt_a1, filt_b0, filt_b1} !== {ma[0], ma[1], ma[2]} || miss_cnt !== 8'(mmiss)) begin
        errors++; $display("FAIL rnd_coef cyc %0d got %h %h %h %0d want %h %h %h %0d", i,
                           filt_a1, filt_b0, filt_b1, miss_cnt, ma[0], ma[1], ma[2], mmiss);
      end
      in_valid   = ($urandom_range(0, 2) == 0);
      in_data    = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_wr     = ($urandom_range(0, 7) == 0);
      cfg_addr   = 2'($urandom_range(0, 3));
      cfg_data   = $urandom;
      cfg_commit = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0; out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 * DIV * DEPTH && !ok; i++) begin @(negedge clk); ok = !busy; end
    checks++;
    if (!ok) begin errors++; $display("FAIL rnd_drain got busy want idle"); end
  endtask

  task automatic test_reset_mid_out();
    bit ok;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = $urandom;
    end
    @(negedge clk); in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 3 * DIV && !ok; i++) begin @(negedge clk); ok = out_valid; end
    checks++;
    if (!ok || busy !== 1'b1) begin errors++; $display("FAIL rmo_setup got v=%b busy=%b want 1 1", out_valid, busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL rmo_flags got %b want 010", {out_valid, in_ready, busy});
    end
    checks++;
    if ({filt_a1, filt_b0, filt_b1} !== '0) begin
      errors++; $display("FAIL rmo_coef got %h %h %h want 0", filt_a1, filt_b0, filt_b1);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    repeat (2 * DIV) begin
      @(negedge clk);
      checks++;
      if (filt_en !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rmo_discard got en=%b busy=%b want 0 0", filt_en, busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty_ticks();
    test_coef_commit();
    test_basic_issue();
    test_backpressure();
    test_fifo_full();
    test_random();
    test_reset_mid_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
